// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared opcode/state types and default memory wait for the writeback stage
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD,
        WB_STORE
    } wb_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_WRITE
    } wb_state_t;

    localparam int WB_MEM_WAIT = 2;

endpackage

// File: rtl/wb_dmem.sv
// wb_dmem: synchronous-write, registered-read byte memory; never reset so contents survive rst_n
module wb_dmem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    input  logic          re,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    // Write and read share one address; the read lands in rdata one edge after re
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with wait-stated data memory; WB_BYPASS_EN adds forwarding outputs
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int raw      = 4,
    parameter int MEM_AW   = 8,
    parameter int MEM_WAIT = WB_MEM_WAIT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  wb_op_t         in_op,
    input  logic           in_to_acc,
    input  logic [raw-1:0] in_dst,
    input  logic [7:0]     in_result,
    input  logic [7:0]     in_store_data,
    output logic           acc_wen,
    output logic           reg_wen,
    output logic [raw-1:0] write_addr_o,
    output logic [7:0]     write_data_o,
    output logic           busy_o
`ifdef WB_BYPASS_EN
    ,
    output logic           fwd_valid_o,
    output logic           fwd_acc_o,
    output logic [raw-1:0] fwd_addr_o,
    output logic [7:0]     fwd_data_o
`endif
);

    wb_state_t         state, state_n;
    logic [2:0]        cnt;
    logic [MEM_AW-1:0] maddr;
    logic [7:0]        mwdata;
    logic              mload;
    logic              to_acc;
    logic [raw-1:0]    dst;
    logic [7:0]        data;
    logic              from_mem;
    logic [7:0]        rdata;
    logic              accept, mem_go;

    assign in_ready = state != S_MEM;
    assign busy_o   = state == S_MEM;
    assign accept   = in_valid && in_ready;
    assign mem_go   = state == S_MEM && cnt == 3'd0;

    // Next state: memory waits count down, otherwise follow the accepted op or drop to idle
    always_comb begin
        state_n = S_IDLE;
        if (state == S_MEM)
            state_n = cnt != 3'd0 ? S_MEM : (mload ? S_WRITE : S_IDLE);
        else if (accept)
            state_n = in_op == WB_ALU ? S_WRITE : (in_op == WB_NONE ? S_IDLE : S_MEM);
    end

    // State, wait counter and latched transaction fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            maddr    <= '0;
            mwdata   <= 8'd0;
            mload    <= 1'b0;
            to_acc   <= 1'b0;
            dst      <= '0;
            data     <= 8'd0;
            from_mem <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_MEM) cnt <= cnt - 3'd1;
            if (accept && in_op == WB_ALU) begin
                data     <= in_result;
                dst      <= in_dst;
                to_acc   <= in_to_acc;
                from_mem <= 1'b0;
            end
            if (accept && (in_op == WB_LOAD || in_op == WB_STORE)) begin
                cnt    <= 3'(MEM_WAIT - 1);
                maddr  <= in_result[MEM_AW-1:0];
                mwdata <= in_store_data;
                mload  <= in_op == WB_LOAD;
            end
            if (accept && in_op == WB_LOAD) begin
                dst      <= in_dst;
                to_acc   <= in_to_acc;
                from_mem <= 1'b1;
            end
        end
    end

    wb_dmem #(.AW(MEM_AW)) u_dmem (
        .clk   (clk),
        .we    (mem_go && !mload),
        .addr  (maddr),
        .wdata (mwdata),
        .re    (mem_go && mload),
        .rdata (rdata)
    );

    // Load results come straight from the memory read register, ALU results from the latch
    assign write_data_o = from_mem ? rdata : data;
    assign write_addr_o = to_acc ? '0 : dst;
    assign acc_wen      = state == S_WRITE && to_acc;
    assign reg_wen      = state == S_WRITE && !to_acc;

`ifdef WB_BYPASS_EN
    assign fwd_valid_o = acc_wen | reg_wen;
    assign fwd_acc_o   = fwd_valid_o & to_acc;
    assign fwd_addr_o  = fwd_valid_o ? write_addr_o : '0;
    assign fwd_data_o  = fwd_valid_o ? write_data_o : 8'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table vectors, directed memory/reset sequences and a scheduled-write reference model
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int RAW = 4;
    localparam int AW  = 8;
    localparam int MW  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    wb_op_t         in_op = WB_NONE;
    logic           in_to_acc = 1'b0;
    logic [RAW-1:0] in_dst = '0;
    logic [7:0]     in_result = 8'd0;
    logic [7:0]     in_store_data = 8'd0;
    logic           acc_wen, reg_wen, busy_o;
    logic [RAW-1:0] write_addr_o;
    logic [7:0]     write_data_o;
`ifdef WB_BYPASS_EN
    logic           fwd_valid_o, fwd_acc_o;
    logic [RAW-1:0] fwd_addr_o;
    logic [7:0]     fwd_data_o;
`endif

    int errors = 0;
    int checks = 0;

    wb_stage #(.raw(RAW), .MEM_AW(AW), .MEM_WAIT(MW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_to_acc     (in_to_acc),
        .in_dst        (in_dst),
        .in_result     (in_result),
        .in_store_data (in_store_data),
        .acc_wen       (acc_wen),
        .reg_wen       (reg_wen),
        .write_addr_o  (write_addr_o),
        .write_data_o  (write_data_o),
        .busy_o        (busy_o)
`ifdef WB_BYPASS_EN
        ,
        .fwd_valid_o   (fwd_valid_o),
        .fwd_acc_o     (fwd_acc_o),
        .fwd_addr_o    (fwd_addr_o),
        .fwd_data_o    (fwd_data_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        wb_op_t         op;
        logic           ta;
        logic [RAW-1:0] d;
        logic [7:0]     res;
        logic           ea;
        logic           er;
        logic [RAW-1:0] eaddr;
        logic [7:0]     edata;
        logic           f;
    } vec_t;

    typedef struct {
        int             e;
        logic           acc;
        logic [RAW-1:0] addr;
        logic [7:0]     data;
    } wr_t;

    vec_t       tv [7];
    wr_t        q [$];
    logic [7:0] mm [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input wb_op_t op, input logic ta, input logic [RAW-1:0] d,
                         input logic [7:0] res, input logic [7:0] sd);
        in_valid = 1'b1;
        in_op = op;
        in_to_acc = ta;
        in_dst = d;
        in_result = res;
        in_store_data = sd;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_acc"}, acc_wen, 0);
        chk({nm, "_reg"}, reg_wen, 0);
        chk({nm, "_addr"}, write_addr_o, 0);
        chk({nm, "_data"}, write_data_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_ready"}, in_ready, 1);
`ifdef WB_BYPASS_EN
        chk({nm, "_fwdv"}, fwd_valid_o, 0);
        chk({nm, "_fwdd"}, fwd_data_o, 0);
`endif
    endtask

    // Called at a negedge where the stage is ready; returns at the negedge after completion
    task automatic mem_seq(input string nm, input wb_op_t op, input logic ta, input logic [RAW-1:0] d,
                           input logic [7:0] a, input logic [7:0] sd, input logic [7:0] ed);
        drive(op, ta, d, a, sd);
        if (op == WB_STORE) mm[a] = sd;
        for (int c = 0; c < MW; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk({nm, "_wait_ready"}, in_ready, 0);
            chk({nm, "_wait_busy"}, busy_o, 1);
            chk({nm, "_wait_wen"}, acc_wen | reg_wen, 0);
        end
        @(negedge clk);
        chk({nm, "_ready"}, in_ready, 1);
        chk({nm, "_busy"}, busy_o, 0);
        if (op == WB_LOAD) begin
            chk({nm, "_acc"}, acc_wen, ta);
            chk({nm, "_reg"}, reg_wen, !ta);
            chk({nm, "_addr"}, write_addr_o, ta ? 0 : d);
            chk({nm, "_data"}, write_data_o, ed);
        end else begin
            chk({nm, "_wen"}, acc_wen | reg_wen, 0);
        end
    endtask

    initial begin
        tv[0] = '{WB_ALU,  1'b1, 4'd0,  8'h5A, 1'b1, 1'b0, 4'd0,  8'h5A, 1'b1};
        tv[1] = '{WB_ALU,  1'b1, 4'd9,  8'h01, 1'b1, 1'b0, 4'd0,  8'h01, 1'b1};
        tv[2] = '{WB_ALU,  1'b0, 4'd5,  8'h9E, 1'b0, 1'b1, 4'd5,  8'h9E, 1'b1};
        tv[3] = '{WB_ALU,  1'b0, 4'd15, 8'hFF, 1'b0, 1'b1, 4'd15, 8'hFF, 1'b1};
        tv[4] = '{WB_ALU,  1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd0,  8'h00, 1'b1};
        tv[5] = '{WB_NONE, 1'b0, 4'd3,  8'h77, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
        tv[6] = '{WB_ALU,  1'b0, 4'd3,  8'h11, 1'b0, 1'b1, 4'd3,  8'h11, 1'b1};

        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive(tv[i].op, tv[i].ta, tv[i].d, tv[i].res, 8'h00);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_acc", i), acc_wen, tv[i].ea);
            chk($sformatf("vec%0d_reg", i), reg_wen, tv[i].er);
            if (tv[i].f) begin
                chk($sformatf("vec%0d_addr", i), write_addr_o, tv[i].eaddr);
                chk($sformatf("vec%0d_data", i), write_data_o, tv[i].edata);
            end
`ifdef WB_BYPASS_EN
            chk($sformatf("vec%0d_fwdv", i), fwd_valid_o, tv[i].ea | tv[i].er);
            if (tv[i].f) begin
                chk($sformatf("vec%0d_fwda", i), fwd_acc_o, tv[i].ea);
                chk($sformatf("vec%0d_fwdaddr", i), fwd_addr_o, tv[i].eaddr);
                chk($sformatf("vec%0d_fwdd", i), fwd_data_o, tv[i].edata);
            end
`endif
            @(negedge clk);
            chk($sformatf("vec%0d_once", i), acc_wen | reg_wen, 0);
        end

        begin
            logic [RAW-1:0] sd [3];
            logic [7:0]     sv [3];
            sd[0] = 4'd3;  sd[1] = 4'd7;  sd[2] = 4'd15;
            sv[0] = 8'h11; sv[1] = 8'h22; sv[2] = 8'h33;
            drive(WB_ALU, 1'b0, sd[0], sv[0], 8'h00);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk($sformatf("stream%0d_reg", i), reg_wen, 1);
                chk($sformatf("stream%0d_acc", i), acc_wen, 0);
                chk($sformatf("stream%0d_addr", i), write_addr_o, sd[i]);
                chk($sformatf("stream%0d_data", i), write_data_o, sv[i]);
                if (i < 2) drive(WB_ALU, 1'b0, sd[i+1], sv[i+1], 8'h00);
                else in_valid = 1'b0;
            end
            @(negedge clk);
            chk("stream_end", acc_wen | reg_wen, 0);
        end

        drive(WB_ALU, 1'b0, 4'd7, 8'hAB, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_pre", reg_wen, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mem_seq("st40", WB_STORE, 1'b0, 4'd0, 8'h40, 8'hC3, 8'h00);
        mem_seq("ld40", WB_LOAD,  1'b0, 4'd2, 8'h40, 8'h00, 8'hC3);
        mem_seq("st40b", WB_STORE, 1'b0, 4'd0, 8'h40, 8'h77, 8'h00);
        mem_seq("ld40acc", WB_LOAD, 1'b1, 4'd6, 8'h40, 8'h00, 8'h77);

        mem_seq("pre10", WB_STORE, 1'b0, 4'd0, 8'h10, 8'h5C, 8'h00);
        drive(WB_STORE, 1'b0, 4'd0, 8'h10, 8'hFF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("memrst_busy", busy_o, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("memrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < MW + 1; c++) begin
            @(negedge clk);
            chk("memrst_quiet", acc_wen | reg_wen | busy_o, 0);
        end
        mem_seq("ld10", WB_LOAD, 1'b1, 4'd0, 8'h10, 8'h00, 8'h5C);

        for (int i = 0; i < 8; i++)
            mem_seq($sformatf("pre8%0d", i), WB_STORE, 1'b0, 4'd0, 8'(8'h80 + i), 8'($urandom_range(0, 255)), 8'h00);

        begin
            int     k = 0;
            int     nxt = 1;
            logic   rdy;
            wr_t    w;
            wb_op_t op;
            logic   ta;
            logic [RAW-1:0] d;
            logic [7:0] a, sdv;
            for (int n = 0; n < 400; n++) begin
                rdy = (k + 1 >= nxt);
                chk("rnd_ready", in_ready, rdy);
                chk("rnd_busy", busy_o, !rdy);
                if (q.size() > 0 && q[0].e == k) begin
                    w = q.pop_front();
                    chk("rnd_acc", acc_wen, w.acc);
                    chk("rnd_reg", reg_wen, !w.acc);
                    chk("rnd_addr", write_addr_o, w.acc ? 0 : w.addr);
                    chk("rnd_data", write_data_o, w.data);
                end else begin
                    chk("rnd_nowen", acc_wen | reg_wen, 0);
                end
                op  = wb_op_t'($urandom_range(0, 3));
                ta  = 1'($urandom_range(0, 1));
                d   = 4'($urandom_range(0, 15));
                sdv = 8'($urandom_range(0, 255));
                a   = (op == WB_LOAD || op == WB_STORE) ? 8'(8'h80 + $urandom_range(0, 7))
                                                        : 8'($urandom_range(0, 255));
                drive(op, ta, d, a, sdv);
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid && rdy) begin
                    if (op == WB_ALU) begin
                        w = '{k + 1, ta, d, a};
                        q.push_back(w);
                        nxt = k + 2;
                    end else if (op == WB_LOAD) begin
                        w = '{k + 1 + MW, ta, d, mm[a]};
                        q.push_back(w);
                        nxt = k + 2 + MW;
                    end else if (op == WB_STORE) begin
                        mm[a] = sdv;
                        nxt = k + 2 + MW;
                    end else begin
                        nxt = k + 2;
                    end
                end
                @(negedge clk);
                k++;
            end
            in_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 8-bit accumulator CPU, sitting directly upstream of the register file. It accepts one completed instruction per handshake from the execute stage. For ALU results it produces a registered write strobe to the accumulator or a general register. For loads and stores it runs a wait-stated access to an internal data memory, and returns the load data through the same write strobe.

## Interface
Parameters:
- raw, 4, register-file address width (2**raw registers)
- MEM_AW, 8, data-memory address width (2**MEM_AW bytes)
- MEM_WAIT, 2, memory wait cycles, legal range 1..7

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_op  input  2  wb_op_t: WB_NONE, WB_ALU, WB_LOAD, WB_STORE
- in_to_acc  input  1  1 = destination is accumulator (RF[0]); 0 = RF[in_dst]
- in_dst  input  raw  destination register address
- in_result  input  8  ALU result (WB_ALU) or memory address (WB_LOAD/WB_STORE, low MEM_AW bits)
- in_store_data  input  8  store data (WB_STORE)
- acc_wen  output  1  accumulator write strobe to register file
- reg_wen  output  1  general register write strobe to register file
- write_addr_o  output  raw  register write address
- write_data_o  output  8  register write data
- busy_o  output  1  memory access in progress

## Operation
- Handshake: transfer occurs on a rising edge with in_valid && in_ready. Inputs are sampled only on transfer.
- in_ready = (state != S_MEM). It is combinational from state.
- FSM states, in wb_state_t:
  - S_IDLE: no pending write.
  - S_WRITE: write strobe asserted this cycle.
  - S_MEM: memory wait.
- Transfers from S_IDLE or S_WRITE:
  - WB_NONE -> S_IDLE. No strobes.
  - WB_ALU -> S_WRITE. Latch write_data_o = in_result and write_addr_o = in_dst.
  - WB_LOAD / WB_STORE -> S_MEM. Load wait counter with MEM_WAIT-1, latch address, data and destination.
- S_MEM:
  - Counter decrements each cycle.
  - At count 0 the memory is accessed. Store writes mem[addr] and goes to S_IDLE. Load registers mem[addr] into write_data_o and goes to S_WRITE.
- S_WRITE with no transfer -> S_IDLE.
- Strobe encoding: in S_WRITE exactly one of acc_wen/reg_wen is high, selected by the latched to_acc. Both strobes are low in every other state.
- When to_acc = 1, write_addr_o is driven 0.
- busy_o = (state == S_MEM).
- Memory is not reset. Its contents survive rst_n.

## Timing
- Reset values: state S_IDLE, acc_wen 0, reg_wen 0, write_addr_o 0, write_data_o 0, busy_o 0. in_ready is 1 in reset.
- WB_ALU accepted at edge N: strobe is high during cycle N..N+1 and is written into the register file at edge N+1. Latency is 1.
- WB_LOAD accepted at edge N: strobe is high in the cycle after edge N+MEM_WAIT. Latency is MEM_WAIT+1 edges.
- WB_STORE accepted at edge N: memory is written at edge N+MEM_WAIT. in_ready returns high at that edge.
- Back-to-back: WB_ALU streams at one per cycle with continuous strobes. The new transfer in S_WRITE replaces the latched write fields at the same edge.
- Load followed by a store to the same address: the load reads the old data, because accesses are strictly ordered.
- Reset asserted mid S_MEM: the access is abandoned. No memory write and no strobe occur after release.

## Configuration
- WB_BYPASS_EN defined:
  - Adds outputs fwd_valid_o (1), fwd_acc_o (1), fwd_addr_o (raw) and fwd_data_o (8).
  - These mirror the S_WRITE write fields combinationally, so execute can forward before the register file updates.
  - fwd_valid_o = acc_wen | reg_wen. All four outputs reset to 0.
- WB_BYPASS_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package definitions: wb_op_t (2-bit enum) and wb_state_t (enum S_IDLE/S_MEM/S_WRITE).
- The default MEM_WAIT constant lives in definitions.
- One sub-module, wb_dmem: synchronous-write, registered-read 2**MEM_AW x 8 memory with we, addr, wdata, re, rdata.

## Test plan
- Reset: hold rst_n=0 mid-cycle -> all outputs 0 immediately, in_ready=1.
- ALU to acc: WB_ALU, in_to_acc=1, in_result=8'h5A -> acc_wen=1, reg_wen=0, write_data_o=8'h5A one cycle later, for exactly one cycle.
- ALU stream: three WB_ALU to RF[3], RF[7], RF[15] with 8'h11, 8'h22, 8'h33 -> three consecutive reg_wen cycles with matching addr/data.
- Store then load: WB_STORE addr 8'h40 data 8'hC3, then WB_LOAD addr 8'h40 to RF[2] -> in_ready low for MEM_WAIT cycles each; reg_wen with addr 2, data 8'hC3 at accept+MEM_WAIT+1.
- Reset during S_MEM: WB_STORE addr 8'h10 data 8'hFF, reset one cycle later, then load 8'h10 -> returns the prior value, not 8'hFF.
- WB_BYPASS_EN: WB_ALU RF[5] data 8'h9E -> fwd_valid_o=1, fwd_addr_o=5, fwd_data_o=8'h9E in the same cycle as reg_wen.
